// File: rtl/led_chaser_pkg.sv
// Shared definitions for the LED sequencer: pattern mode encodings.
package led_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage

// File: rtl/led_chaser_tick_prescaler.sv
// Clock-enable prescaler: emits a one-cycle step every div+1 enabled cycles.
module tick_prescaler #(
    parameter int DIV_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so lowering div mid-count steps at once instead of wrapping
    assign step = en && (cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_chaser.sv
// Parametrised LED sequencer: rotate, bounce, fill-bar and hold patterns
// stepped at a programmable rate from a clock-enable prescaler.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter  int N_LEDS = 4,
    parameter  int DIV_W  = 6,
    localparam int POS_W  = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    output logic [N_LEDS-1:0] leds,
    output logic [POS_W-1:0]  pos,
    output logic              tick
);

    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

    logic             step;
    logic             bdir;
    logic             bounce_up;
    mode_t            mode_in;
    mode_t            mode_q;
    logic [POS_W-1:0] pos_up;
    logic [POS_W-1:0] pos_dn;

    tick_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .div (div),
        .step(step)
    );

    assign mode_in = mode_t'(mode);

    always_comb begin
        pos_up    = (pos == LAST) ? '0 : pos + POS_W'(1);
        pos_dn    = (pos == '0) ? LAST : pos - POS_W'(1);
        // dir seeds the sweep only on the step that enters bounce
        bounce_up = (mode_in == MODE_BOUNCE && mode_q != MODE_BOUNCE) ? dir : bdir;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos    <= '0;
            mode_q <= MODE_ROTATE;
            bdir   <= 1'b1;
            tick   <= 1'b0;
        end else begin
            tick <= step;
            if (step) begin
                mode_q <= mode_in;
                case (mode_in)
                    MODE_ROTATE, MODE_FILL: pos <= dir ? pos_up : pos_dn;
                    MODE_BOUNCE: begin
                        if (bounce_up) begin
                            if (pos == LAST) begin
                                bdir <= 1'b0;
                                pos  <= LAST - POS_W'(1);
                            end else begin
                                bdir <= 1'b1;
                                pos  <= pos + POS_W'(1);
                            end
                        end else begin
                            if (pos == '0) begin
                                bdir <= 1'b1;
                                pos  <= POS_W'(1);
                            end else begin
                                bdir <= 1'b0;
                                pos  <= pos - POS_W'(1);
                            end
                        end
                    end
                    MODE_HOLD: pos <= pos;
                endcase
            end
        end
    end

    always_comb begin
        leds = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (mode_q == MODE_FILL) begin
                leds[i] = (i <= 32'(pos));
            end else begin
                leds[i] = (i == 32'(pos));
            end
        end
    end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser (N_LEDS=4, DIV_W=6): per-cycle vector
// table plus hand-written sequences for reset, long prescale and enable gaps.
module tb_led_chaser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       dir = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [5:0] div = '0;
    logic [3:0] leds;
    logic [1:0] pos;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       en;
        logic       dir;
        logic [1:0] mode;
        logic [5:0] div;
        logic [1:0] pos;
        logic [3:0] leds;
        logic       tick;
    } vec_t;

    vec_t vecs[$];
    int   vec_idx = 0;

    led_chaser #(
        .N_LEDS(4),
        .DIV_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .dir (dir),
        .mode(mode),
        .div (div),
        .leds(leds),
        .pos (pos),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic d, input logic [1:0] m, input logic [5:0] dv,
                       input logic [1:0] p, input logic [3:0] l, input logic t);
        vec_t v;
        v.en = e; v.dir = d; v.mode = m; v.div = dv;
        v.pos = p; v.leds = l; v.tick = t;
        vecs.push_back(v);
    endtask

    // Each vector drives inputs, takes one rising edge, then checks outputs 1ns later.
    task automatic run_table();
        foreach (vecs[i]) begin
            en = vecs[i].en; dir = vecs[i].dir; mode = vecs[i].mode; div = vecs[i].div;
            @(posedge clk); #1;
            check("pos",  vec_idx, 32'(pos),  32'(vecs[i].pos));
            check("leds", vec_idx, 32'(leds), 32'(vecs[i].leds));
            check("tick", vec_idx, 32'(tick), 32'(vecs[i].tick));
            vec_idx++;
        end
        vecs.delete();
    endtask

    task automatic cycles(input int n, input logic [1:0] exp_pos, input string name);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check({name, " tick"}, k, 32'(tick), 32'd0);
            check({name, " pos"},  k, 32'(pos),  32'(exp_pos));
        end
    endtask

    task automatic one_step(input logic [1:0] exp_pos, input string name);
        @(posedge clk); #1;
        check({name, " tick"}, 0, 32'(tick), 32'd1);
        check({name, " pos"},  0, 32'(pos),  32'(exp_pos));
    endtask

    initial begin
        #12;
        check("reset pos",  0, 32'(pos),  32'd0);
        check("reset leds", 0, 32'(leds), 32'h1);
        check("reset tick", 0, 32'(tick), 32'd0);
        @(negedge clk); rst = 1'b0;

        // ROTATE up, div=2: step every 3 cycles, then down
        add(1,1,2'b00,2, 0,4'h1,0); add(1,1,2'b00,2, 0,4'h1,0); add(1,1,2'b00,2, 1,4'h2,1);
        add(1,1,2'b00,2, 1,4'h2,0); add(1,1,2'b00,2, 1,4'h2,0); add(1,1,2'b00,2, 2,4'h4,1);
        add(1,1,2'b00,2, 2,4'h4,0); add(1,1,2'b00,2, 2,4'h4,0); add(1,1,2'b00,2, 3,4'h8,1);
        add(1,1,2'b00,2, 3,4'h8,0); add(1,1,2'b00,2, 3,4'h8,0); add(1,1,2'b00,2, 0,4'h1,1);
        add(1,0,2'b00,2, 0,4'h1,0); add(1,0,2'b00,2, 0,4'h1,0); add(1,0,2'b00,2, 3,4'h8,1);
        add(1,0,2'b00,2, 3,4'h8,0); add(1,0,2'b00,2, 3,4'h8,0); add(1,0,2'b00,2, 2,4'h4,1);
        run_table();

        // Asynchronous reset while tick is high and pos=2
        #2 rst = 1'b1; #1;
        check("async rst pos",  0, 32'(pos),  32'd0);
        check("async rst leds", 0, 32'(leds), 32'h1);
        check("async rst tick", 0, 32'(tick), 32'd0);
        @(negedge clk); rst = 1'b0;

        // BOUNCE from 0, div=0; dir toggles after entry are ignored
        add(1,1,2'b01,0, 1,4'h2,1); add(1,1,2'b01,0, 2,4'h4,1); add(1,1,2'b01,0, 3,4'h8,1);
        add(1,0,2'b01,0, 2,4'h4,1); add(1,0,2'b01,0, 1,4'h2,1); add(1,1,2'b01,0, 0,4'h1,1);
        add(1,0,2'b01,0, 1,4'h2,1);
        // one ROTATE-down step back to 0, then FILL down
        add(1,0,2'b00,0, 0,4'h1,1);
        add(1,0,2'b10,0, 3,4'hF,1); add(1,0,2'b10,0, 2,4'h7,1); add(1,0,2'b10,0, 1,4'h3,1);
        add(1,0,2'b10,0, 0,4'h1,1); add(1,0,2'b10,0, 3,4'hF,1);
        // en low on a cycle that would otherwise step
        add(0,0,2'b10,0, 3,4'hF,0);
        // HOLD, div=1: mode_q switches only at the first step, 4 ticks, pos fixed
        add(1,0,2'b11,1, 3,4'hF,0); add(1,0,2'b11,1, 3,4'h8,1); add(1,0,2'b11,1, 3,4'h8,0);
        add(1,0,2'b11,1, 3,4'h8,1); add(1,0,2'b11,1, 3,4'h8,0); add(1,0,2'b11,1, 3,4'h8,1);
        add(1,0,2'b11,1, 3,4'h8,0); add(1,0,2'b11,1, 3,4'h8,1);
        // switch to ROTATE up: no effect until the next step
        add(1,1,2'b00,1, 3,4'h8,0); add(1,1,2'b00,1, 0,4'h1,1);
        run_table();

        // Long prescale: count to 40 with div=63, then lower div to 5
        en = 1'b1; dir = 1'b1; mode = 2'b00; div = 6'd63;
        cycles(40, 2'd0, "div63");
        div = 6'd5;
        one_step(2'd1, "div lowered");
        cycles(5, 2'd1, "div5 a");
        one_step(2'd2, "div5 step2");
        cycles(5, 2'd2, "div5 b");
        one_step(2'd3, "div5 step3");
        cycles(3, 2'd3, "pre-disable");
        // en low clears the partial count of 3
        en = 1'b0;
        cycles(10, 2'd3, "disabled");
        en = 1'b1;
        cycles(5, 2'd3, "re-enable");
        one_step(2'd0, "re-enable step");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
